// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline register: memory op codes,
// WB control bit positions, default field widths and the payload layout.
package ex_mem_pkg;

  typedef enum logic [1:0] {
    MOP_NONE = 2'b00,
    MOP_BYTE = 2'b01,
    MOP_HALF = 2'b10,
    MOP_WORD = 2'b11
  } mem_op_e;

  localparam int WB_REGWR_BIT = 1;
  localparam int M_W          = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RADDR_W  = 5;
  localparam int DEF_WB_W     = 2;
  localparam int DEF_CNT_W    = 16;

  // Payload is packed MSB-first as {wb, m, alu, sdata, rd}
  typedef struct packed {
    logic [DEF_WB_W-1:0]    wb;
    logic [M_W-1:0]         m;
    logic [DEF_DATA_W-1:0]  alu;
    logic [DEF_DATA_W-1:0]  sdata;
    logic [DEF_RADDR_W-1:0] rd;
  } ex_mem_payload_t;

  function automatic int payload_w(int data_w, int raddr_w, int wb_w);
    return wb_w + M_W + 2 * data_w + raddr_w;
  endfunction

endpackage

// File: rtl/ex_mem_skid_reg_skid_buf.sv
// Generic 2-slot valid/ready skid buffer: a main output slot plus one skid
// slot that absorbs the entry accepted while the consumer stalls.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
);

  logic                 main_valid, skid_valid;
  logic [PAYLOAD_W-1:0] main_data, skid_data;
  logic                 main_valid_nxt, skid_valid_nxt;
  logic [PAYLOAD_W-1:0] main_data_nxt, skid_data_nxt;
  logic [1:0]           occ_q;
  logic                 accept, drain;

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = occ_q;

  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    main_data_nxt  = main_data;
    skid_data_nxt  = skid_data;
    if (flush) begin
      // Payload registers keep their contents; only the valid bits drop
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (drain && skid_valid) begin
      main_data_nxt  = skid_data;
      skid_valid_nxt = 1'b0;
    end else if (drain || !main_valid) begin
      main_valid_nxt = accept;
      if (accept) main_data_nxt = in_data;
    end else if (accept) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      occ_q      <= 2'd0;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      main_data  <= main_data_nxt;
      skid_data  <= skid_data_nxt;
      occ_q      <= {1'b0, main_valid_nxt} + {1'b0, skid_valid_nxt};
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with valid/ready skid buffering, flush, a
// MEM-stage forwarding tap and a saturating backpressure counter.
module ex_mem_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int WB_W    = DEF_WB_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [WB_W-1:0]    ex_wb,
  input  logic [3:0]         ex_m,
  input  logic [DATA_W-1:0]  ex_alu,
  input  logic [DATA_W-1:0]  ex_sdata,
  input  logic [RADDR_W-1:0] ex_rd,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [1:0]         mem_rd_op,
  output logic [1:0]         mem_wr_op,
  output logic [WB_W-1:0]    mem_wb,
  output logic [DATA_W-1:0]  mem_alu,
  output logic [DATA_W-1:0]  mem_sdata,
  output logic [RADDR_W-1:0] mem_rdst,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PW = payload_w(DATA_W, RADDR_W, WB_W);

  logic [PW-1:0]      in_data, out_data;
  logic [WB_W-1:0]    wb_q;
  logic [3:0]         m_q;
  logic [DATA_W-1:0]  alu_q, sdata_q;
  logic [RADDR_W-1:0] rd_q;

  assign in_data = {ex_wb, ex_m, ex_alu, ex_sdata, ex_rd};

  pipe_skid_buf #(.PAYLOAD_W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_data   (in_data),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  assign {wb_q, m_q, alu_q, sdata_q, rd_q} = out_data;

  // Control fields are gated so a stale payload never issues a memory op or writeback
  assign mem_rd_op = mem_valid ? m_q[3:2] : MOP_NONE;
  assign mem_wr_op = mem_valid ? m_q[1:0] : MOP_NONE;
  assign mem_wb    = mem_valid ? wb_q : '0;
  assign mem_alu   = alu_q;
  assign mem_sdata = sdata_q;
  assign mem_rdst  = rd_q;

  assign fwd_valid = mem_valid & wb_q[WB_REGWR_BIT] & (rd_q != '0);
  assign fwd_rd    = rd_q;
  assign fwd_data  = alu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (mem_valid && !mem_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
